// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM states, default widths,
// and the word-alignment check applied to incoming command addresses.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB3 requester signals for apb_master_bridge.
// The master modport is the bridge; the slave modport is the controller/APB side.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_access_timer.sv
// Counts ACCESS cycles spent waiting for PREADY; flags the cycle in which the
// count reaches TIMEOUT_CYCLES. Built only with APB_TIMEOUT_EN.
module apb_access_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_W'(0);
        end else if (clear) begin
            count <= CNT_W'(0);
        end else if (tick) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is the waiting cycle whose increment would land on TIMEOUT_CYCLES.
    assign expired_c = tick && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: valid/ready commands in, SETUP/ACCESS transfers out, one-cycle response pulse.
// Optional feature macro APB_TIMEOUT_EN bounds the PREADY wait to TIMEOUT_CYCLES ACCESS cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);

    apb_state_e state;
    logic       misaligned_c;
    logic       timeout_c;

    assign misaligned_c  = is_misaligned(bus.cmd_addr[1:0]);
    assign bus.cmd_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
    logic timer_clear_c;
    logic timer_tick_c;

    assign timer_clear_c = (state == SETUP);
    assign timer_tick_c  = (state == ACCESS) && !bus.PREADY;

    apb_access_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_access_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .clear     (timer_clear_c),
        .tick      (timer_tick_c),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Transfer sequencer; every bus and response output is registered here.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state         <= IDLE;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= ADDR_W'(0);
            bus.PWDATA    <= DATA_W'(0);
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= DATA_W'(0);
            bus.rsp_error <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (misaligned_c) begin
                            // Rejected without touching the bus.
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_error <= 1'b1;
                            bus.rsp_rdata <= DATA_W'(0);
                        end else begin
                            bus.PWRITE <= bus.cmd_write;
                            bus.PADDR  <= bus.cmd_addr;
                            bus.PWDATA <= bus.cmd_wdata;
                            bus.PSEL   <= 1'b1;
                            state      <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_error <= bus.PSLVERR;
                        if (bus.PWRITE || bus.PSLVERR) begin
                            bus.rsp_rdata <= DATA_W'(0);
                        end else begin
                            bus.rsp_rdata <= bus.PRDATA;
                        end
                        state <= IDLE;
                    end else if (timeout_c) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_error <= 1'b1;
                        bus.rsp_rdata <= DATA_W'(0);
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.PSEL    <= 1'b0;
                    bus.PENABLE <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed spec cases, randomized traffic
// against a transaction-level model, back-to-back, timeout/hang and mid-transfer reset.
module tb_apb_master_bridge;

    logic PCLK = 1'b0;
    logic PRESET;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

`ifdef APB_TIMEOUT_EN
    localparam int TO_CYC = 16;
`endif

    int checks   = 0;
    int failures = 0;

    // Slave behaviour knobs and storage.
    int          sl_waits = 0;
    bit          sl_err   = 1'b0;
    bit          sl_hang  = 1'b0;
    int          sl_cnt   = 0;
    logic [31:0] sl_mem [logic [31:0]];

    // Reference memory: what a correct requester leaves in the slave.
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        int          lat;
        logic        eerr;
        logic [31:0] edata;
        int          psel;
        int          pen;
    } dir_t;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // APB slave: inserts sl_waits wait states, answers from sl_mem, junk outside ACCESS.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'h0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            if (bus.PSEL && bus.PENABLE) begin
                sl_cnt++;
                if (!sl_hang && sl_cnt > sl_waits) begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = sl_err;
                    if (bus.PWRITE) begin
                        bus.PRDATA = $urandom;
                        if (!sl_err) sl_mem[bus.PADDR] = bus.PWDATA;
                    end else begin
                        bus.PRDATA = sl_mem.exists(bus.PADDR) ? sl_mem[bus.PADDR] : 32'h0;
                    end
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = $urandom;
                    bus.PSLVERR = 1'($urandom);
                end
            end else begin
                sl_cnt      = 0;
                bus.PREADY  = 1'($urandom);
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom);
            end
        end
    end

    // Issue one command and observe it; cycle numbers are relative to the accept edge.
    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input int budget,
                           output int lat, output logic r_err, output logic [31:0] r_data,
                           output int psel_at, output int pen_at, output bit hold_ok,
                           output bit rdy_ok, output bit extra_ok);
        logic [31:0] junk;
        lat = -1; psel_at = -1; pen_at = -1;
        hold_ok = 1'b1; rdy_ok = 1'b1; extra_ok = 1'b1;
        r_err = 1'bx; r_data = 32'hx;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        junk = $urandom;
        junk[1:0] = 2'b00;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = junk;
        bus.cmd_wdata = $urandom;
        for (int k = 1; k <= budget; k++) begin
            if (bus.PSEL && psel_at < 0) psel_at = k;
            if (bus.PENABLE && pen_at < 0) pen_at = k;
            if (bus.PSEL && (bus.PADDR !== a || bus.PWRITE !== wr || bus.PWDATA !== d)) hold_ok = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                lat    = k;
                r_err  = bus.rsp_error;
                r_data = bus.rsp_rdata;
                if (bus.cmd_ready !== 1'b1) rdy_ok = 1'b0;
                break;
            end
            if (bus.cmd_ready !== 1'b0) rdy_ok = 1'b0;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (lat > 0) begin
            tick();
            if (bus.PSEL && psel_at < 0) psel_at = lat + 1;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_error !== r_err || bus.rsp_rdata !== r_data ||
                bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) extra_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        PRESET = 1'b1;
        #2;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b exp 00000",
                     {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_error});
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h exp 0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b exp 1", bus.cmd_ready);
        end
        tick();
        tick();
        PRESET = 1'b0;
        tick();
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_release: got %b exp 0001", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_directed();
        dir_t tab [4];
        int lat, psel_at, pen_at;
        logic r_err;
        logic [31:0] r_data;
        bit hold_ok, rdy_ok, extra_ok;
        sl_mem[32'h8]  = 32'h1234_9876;  ref_mem[32'h8]  = 32'h1234_9876;
        sl_mem[32'hC]  = 32'hDEAD_BEEF;  ref_mem[32'hC]  = 32'hDEAD_BEEF;
        tab[0] = '{1'b1, 32'h4, 32'hA5A5_0000, 0, 1'b0, 3, 1'b0, 32'h0,         1,  2};
        tab[1] = '{1'b0, 32'h8, 32'h0,         2, 1'b0, 5, 1'b0, 32'h1234_9876, 1,  2};
        tab[2] = '{1'b0, 32'hC, 32'h0,         0, 1'b1, 3, 1'b1, 32'h0,         1,  2};
        tab[3] = '{1'b1, 32'h6, 32'h5555_AAAA, 0, 1'b0, 1, 1'b1, 32'h0,        -1, -1};
        for (int i = 0; i < 4; i++) begin
            sl_waits = tab[i].waits;
            sl_err   = tab[i].err;
            run_cmd(tab[i].wr, tab[i].addr, tab[i].wdata, 30,
                    lat, r_err, r_data, psel_at, pen_at, hold_ok, rdy_ok, extra_ok);
            checks++;
            if (lat !== tab[i].lat) begin
                failures++;
                $display("FAIL dir%0d latency: got %0d exp %0d", i, lat, tab[i].lat);
            end
            checks++;
            if (r_err !== tab[i].eerr || r_data !== tab[i].edata) begin
                failures++;
                $display("FAIL dir%0d resp: got err=%b data=%h exp err=%b data=%h", i, r_err, r_data, tab[i].eerr, tab[i].edata);
            end
            checks++;
            if (psel_at !== tab[i].psel || pen_at !== tab[i].pen || !hold_ok) begin
                failures++;
                $display("FAIL dir%0d bus: got psel@%0d pen@%0d hold=%b exp psel@%0d pen@%0d hold=1",
                         i, psel_at, pen_at, hold_ok, tab[i].psel, tab[i].pen);
            end
            checks++;
            if (!rdy_ok || !extra_ok) begin
                failures++;
                $display("FAIL dir%0d ready_pulse: got ready_ok=%b pulse_ok=%b exp 1 1", i, rdy_ok, extra_ok);
            end
        end
        ref_mem[32'h4] = 32'hA5A5_0000;
        sl_err = 1'b0;
    endtask

    task automatic test_random();
        int lat, psel_at, pen_at, exp_lat, exp_psel, exp_pen, waits;
        logic r_err, wr, err, mis, exp_err;
        logic [31:0] r_data, a, d, exp_data;
        bit hold_ok, rdy_ok, extra_ok;
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom);
            a     = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d     = $urandom;
            waits = $urandom_range(0, 4);
            err   = ($urandom_range(0, 7) == 0);
            mis   = (a[1:0] != 2'b00);
            exp_lat  = mis ? 1 : 3 + waits;
            exp_err  = mis ? 1'b1 : err;
            exp_data = (mis || wr || err) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
            exp_psel = mis ? -1 : 1;
            exp_pen  = mis ? -1 : 2;
            sl_waits = waits;
            sl_err   = err;
            run_cmd(wr, a, d, 30, lat, r_err, r_data, psel_at, pen_at, hold_ok, rdy_ok, extra_ok);
            if (!mis && wr && !err) ref_mem[a] = d;
            checks++;
            if (lat !== exp_lat) begin
                failures++;
                $display("FAIL rnd%0d latency: got %0d exp %0d (addr=%h waits=%0d)", i, lat, exp_lat, a, waits);
            end
            checks++;
            if (r_err !== exp_err || r_data !== exp_data) begin
                failures++;
                $display("FAIL rnd%0d resp: got err=%b data=%h exp err=%b data=%h", i, r_err, r_data, exp_err, exp_data);
            end
            checks++;
            if (psel_at !== exp_psel || pen_at !== exp_pen || !hold_ok) begin
                failures++;
                $display("FAIL rnd%0d bus: got psel@%0d pen@%0d hold=%b exp psel@%0d pen@%0d hold=1",
                         i, psel_at, pen_at, hold_ok, exp_psel, exp_pen);
            end
            checks++;
            if (!rdy_ok || !extra_ok) begin
                failures++;
                $display("FAIL rnd%0d ready_pulse: got ready_ok=%b pulse_ok=%b exp 1 1", i, rdy_ok, extra_ok);
            end
        end
        sl_err = 1'b0;
    endtask

    // Command B held valid during A: ignored while busy, accepted on A's response cycle.
    task automatic test_back_to_back();
        logic [31:0] a_addr, a_data;
        a_addr = 32'h200;
        a_data = $urandom;
        sl_waits = 0;
        sl_err   = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = a_addr;
        bus.cmd_wdata = a_data;
        tick();
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = a_addr;
        bus.cmd_wdata = 32'h0;
        tick();
        checks++;
        if (bus.PSEL !== 1'b1 || bus.PWRITE !== 1'b1 || bus.PWDATA !== a_data) begin
            failures++;
            $display("FAIL b2b_ignore: got psel=%b pwrite=%b pwdata=%h exp 1 1 %h", bus.PSEL, bus.PWRITE, bus.PWDATA, a_data);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_rsp: got rsp_valid=%b cmd_ready=%b exp 1 1", bus.rsp_valid, bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_setup: got psel=%b penable=%b pwrite=%b rsp=%b exp 1 0 0 0",
                     bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid);
        end
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== a_data) begin
            failures++;
            $display("FAIL b2b_second_rsp: got valid=%b err=%b data=%h exp 1 0 %h", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata, a_data);
        end
        ref_mem[a_addr] = a_data;
        tick();
    endtask

    task automatic test_timeout();
        int lat, psel_at, pen_at;
        logic r_err;
        logic [31:0] r_data;
        bit hold_ok, rdy_ok, extra_ok;
`ifdef APB_TIMEOUT_EN
        sl_waits = TO_CYC - 1;
        run_cmd(1'b0, 32'h8, 32'h0, 40, lat, r_err, r_data, psel_at, pen_at, hold_ok, rdy_ok, extra_ok);
        checks++;
        if (lat !== TO_CYC + 2 || r_err !== 1'b0 || r_data !== ref_mem[32'h8]) begin
            failures++;
            $display("FAIL to_boundary: got lat=%0d err=%b data=%h exp %0d 0 %h", lat, r_err, r_data, TO_CYC + 2, ref_mem[32'h8]);
        end
        sl_hang = 1'b1;
        run_cmd(1'b0, 32'h8, 32'h0, 40, lat, r_err, r_data, psel_at, pen_at, hold_ok, rdy_ok, extra_ok);
        checks++;
        if (lat !== TO_CYC + 2 || r_err !== 1'b1 || r_data !== 32'h0 || !extra_ok) begin
            failures++;
            $display("FAIL to_expire: got lat=%0d err=%b data=%h pulse_ok=%b exp %0d 1 0 1", lat, r_err, r_data, extra_ok, TO_CYC + 2);
        end
        sl_hang = 1'b0;
`else
        sl_hang = 1'b1;
        run_cmd(1'b0, 32'h8, 32'h0, 40, lat, r_err, r_data, psel_at, pen_at, hold_ok, rdy_ok, extra_ok);
        checks++;
        if (lat !== -1 || bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
            failures++;
            $display("FAIL hang_wait: got lat=%0d psel=%b penable=%b exp -1 1 1", lat, bus.PSEL, bus.PENABLE);
        end
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        sl_hang = 1'b0;
        tick();
`endif
        sl_waits = 0;
    endtask

    task automatic test_reset_mid();
        int lat, psel_at, pen_at;
        logic r_err;
        logic [31:0] r_data;
        bit hold_ok, rdy_ok, extra_ok, saw_rsp;
        sl_hang = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h10;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
            failures++;
            $display("FAIL mid_access: got psel=%b penable=%b exp 1 1", bus.PSEL, bus.PENABLE);
        end
        #3;
        PRESET = 1'b1;
        #1;
        checks++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin
            failures++;
            $display("FAIL mid_drop: got psel=%b penable=%b exp 0 0", bus.PSEL, bus.PENABLE);
        end
        saw_rsp = 1'b0;
        tick();
        saw_rsp |= bus.rsp_valid;
        PRESET  = 1'b0;
        sl_hang = 1'b0;
        tick();
        saw_rsp |= bus.rsp_valid;
        tick();
        saw_rsp |= bus.rsp_valid;
        checks++;
        if (saw_rsp !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_no_rsp: got saw_rsp=%b cmd_ready=%b exp 0 1", saw_rsp, bus.cmd_ready);
        end
        sl_waits = 1;
        run_cmd(1'b0, 32'h8, 32'h0, 30, lat, r_err, r_data, psel_at, pen_at, hold_ok, rdy_ok, extra_ok);
        checks++;
        if (lat !== 4 || r_err !== 1'b0 || r_data !== ref_mem[32'h8]) begin
            failures++;
            $display("FAIL mid_recover: got lat=%0d err=%b data=%h exp 4 0 %h", lat, r_err, r_data, ref_mem[32'h8]);
        end
        sl_waits = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
